// File: rtl/pipe_credit_pkg.sv
// Shared types for the pipeline-result FIFO and the stages around it.
package pipe_credit_pkg;

  localparam int DEFAULT_DEPTH = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic overflow;
    logic credit_err;
  } status_t;

endpackage

// File: rtl/pipe_credit_ring.sv
// Circular storage for pipe_credit_fifo: array plus wrapping rd/wr pointers.
module pipe_credit_ring #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/pipe_credit_fifo.sv
// Captures no-stall pipeline results into a FIFO and hands out issue credits
// so the issuer can never overrun the storage.
module pipe_credit_fifo
  import pipe_credit_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int PIPE_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_i,
  input  logic                          in_valid_i,
  input  logic [WIDTH-1:0]              in_data_i,
  output logic                          can_issue_o,
  output logic                          out_valid_o,
  output logic [WIDTH-1:0]              out_data_o,
  input  logic                          out_ready_i,
  output logic [cnt_width(DEPTH)-1:0]   count_o,
  output logic                          overflow_o,
  output logic                          credit_err_o
);

  localparam int             CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]    DEPTH_S = (CW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (PIPE_LATENCY < 1)) begin : g_bad_param
    $error("pipe_credit_fifo: DEPTH must be a power of two >= 2 and PIPE_LATENCY >= 1");
  end

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          out_valid_q, out_valid_d;
  status_t       status_q, status_d;

  logic             pop, full, accept;
  logic [CW:0]      occ_sum;
  logic [WIDTH-1:0] rd_data;

  // Same-cycle pops are not credited, keeping out_ready off the can_issue path.
  assign occ_sum     = {1'b0, count_q} + {1'b0, inflight_q};
  assign can_issue_o = occ_sum < DEPTH_S;

  always_comb begin
    pop         = out_valid_q & out_ready_i;
    full        = (count_q == DEPTH_C);
    accept      = in_valid_i & (~full | pop);
    count_d     = count_q;
    inflight_d  = inflight_q;
    status_d    = status_q;

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (in_valid_i & ~accept) status_d.overflow = 1'b1;

    if (issue_i & ~in_valid_i) begin
      if (inflight_q != DEPTH_C) inflight_d = inflight_q + 1'b1;
    end else if (in_valid_i & ~issue_i) begin
      if (inflight_q == '0) status_d.credit_err = 1'b1;
      else                  inflight_d = inflight_q - 1'b1;
    end

    if (issue_i & ~can_issue_o) status_d.credit_err = 1'b1;

    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      inflight_q  <= '0;
      out_valid_q <= 1'b0;
      status_q    <= '0;
    end else begin
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      status_q    <= status_d;
    end
  end

  pipe_credit_ring #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (accept),
    .wr_data_i (in_data_i),
    .rd_en_i   (pop),
    .rd_data_o (rd_data)
  );

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_valid_q ? rd_data : '0;
  assign count_o      = count_q;
  assign overflow_o   = status_q.overflow;
  assign credit_err_o = status_q.credit_err;

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Self-checking bench for pipe_credit_fifo against a queue-based reference.
module tb_pipe_credit_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, issue, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             can_issue, out_valid, overflow, credit_err;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq[$];
  int               m_infl;
  bit               m_ovf, m_err;
  bit               pend;

  always #5 clk = ~clk;

  pipe_credit_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .PIPE_LATENCY (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .issue_i      (issue),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .can_issue_o  (can_issue),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_ready_i  (out_ready),
    .count_o      (count),
    .overflow_o   (overflow),
    .credit_err_o (credit_err)
  );

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_can();
    return (mq.size() + m_infl) < DEPTH;
  endfunction

  task automatic check_outputs();
    check_val("can_issue", {31'b0, can_issue}, {31'b0, exp_can()});
    check_val("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    check_val("out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
    check_val("count", WIDTH'(count), WIDTH'(mq.size()));
    check_val("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check_val("credit_err", {31'b0, credit_err}, {31'b0, m_err});
  endtask

  task automatic model_step(input bit iss, input bit iv, input logic [WIDTH-1:0] d,
                            input bit rdy, input bit r);
    bit can, pop, acc;
    if (r) begin
      mq.delete();
      m_infl = 0;
      m_ovf  = 0;
      m_err  = 0;
      return;
    end
    can = exp_can();
    pop = (mq.size() != 0) && rdy;
    acc = iv && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    if (iv && !acc) m_ovf = 1;
    if (iss && !can) m_err = 1;
    if (iss && !iv) begin
      if (m_infl < DEPTH) m_infl++;
    end else if (iv && !iss) begin
      if (m_infl == 0) m_err = 1;
      else m_infl--;
    end
  endtask

  // Called #1 after a posedge: drive, check pre-edge state, advance one clock.
  task automatic cycle(input bit iss, input bit iv, input logic [WIDTH-1:0] d,
                       input bit rdy, input bit r);
    issue = iss; in_valid = iv; in_data = d; out_ready = rdy; rst = r;
    check_outputs();
    model_step(iss, iv, d, rdy, r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit iss, iv, rdy, r;
    rst = 1'b1; issue = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    pend = 0;
    repeat (2) @(posedge clk);
    model_step(0, 0, '0, 0, 1);
    #1;

    // Idle after reset
    repeat (2) cycle(0, 0, '0, 0, 0);

    // Single issue, result next cycle, consumer ready
    cycle(1, 0, '0, 1, 0);
    cycle(0, 1, 32'h0000_0007, 1, 0);
    check_val("single_head", out_data, 32'h7);
    repeat (2) cycle(0, 0, '0, 1, 0);

    // Fill to DEPTH with consumer stalled
    for (int i = 0; i < 5; i++)
      cycle(i < 4, i > 0, 32'hA + i - 1, 0, 0);
    check_val("fill_can_low", {31'b0, can_issue}, 32'h0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 0);

    // Refill, then push 0xE into a full FIFO while popping
    for (int i = 0; i < 5; i++)
      cycle(i < 4, i > 0, 32'hA + i - 1, 0, 0);
    cycle(0, 1, 32'hE, 1, 0);
    check_val("full_pushpop_cnt", WIDTH'(count), 32'd4);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 0);

    // Full, consumer stalled, forced result -> overflow
    cycle(0, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++)
      cycle(i < 4, i > 0, 32'hA + i - 1, 0, 0);
    cycle(0, 1, 32'hF, 0, 0);
    check_val("ovf_set", {31'b0, overflow}, 32'h1);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 0);

    // Stray result with nothing in flight, then reset mid-stream at count=3
    cycle(0, 0, '0, 0, 1);
    cycle(0, 1, 32'h55, 0, 0);
    check_val("stray_err", {31'b0, credit_err}, 32'h1);
    cycle(0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++)
      cycle(i < 3, i > 0, 32'h20 + i, 0, 0);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 0);

    // Random, issuer obeys credits
    pend = 0;
    for (int i = 0; i < 600; i++) begin
      iss = ($urandom_range(0, 2) != 0) && exp_can();
      iv  = pend;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(iss, iv, $urandom, rdy, 0);
      pend = iss;
    end
    check_val("legal_no_ovf", {31'b0, overflow}, 32'h0);
    check_val("legal_no_err", {31'b0, credit_err}, 32'h0);

    // Random, issuer may cheat, stray results, occasional reset
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      iss = ($urandom_range(0, 1) != 0);
      iv  = pend || ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      cycle(iss, iv, $urandom, rdy, r);
      pend = iss;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
